// File: rtl/dti_deserializer.sv
// dti_deserializer: packs NUM consecutive W_DIN-bit beats from a
// valid/ready consumer port into one W_DIN*NUM-bit word on a valid/ready
// producer port. Beat 0 lands in the least significant slot.
//
// Optional feature macro: DTI_DESER_PIPE_EN
//   undefined : din_ready is low while a word is waiting, so each word costs
//               NUM+1 cycles with both sides always ready.
//   defined   : while a word is waiting, din_ready follows dout_ready. The
//               first beat of the next word is accepted in the same cycle
//               the current word leaves, giving one word per NUM cycles.
//               This adds a combinational path dout_ready -> din_ready.
module dti_deserializer #(
    parameter  int W_DIN  = 16,
    parameter  int NUM    = 4,
    localparam int W_DOUT = W_DIN * NUM
) (
    input  logic              clk,
    input  logic              rst,
    // narrow beat stream in
    input  logic [W_DIN-1:0]  din_data,
    input  logic              din_valid,
    output logic              din_ready,
    // packed word stream out
    output logic [W_DOUT-1:0] dout_data,
    output logic              dout_valid,
    input  logic              dout_ready
);

    // Beat counter width; a single-beat word still needs a 1-bit counter.
    localparam int CW = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic {
        s_fill = 1'b0,
        s_full = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [CW-1:0]     cnt_reg;
    logic [CW-1:0]     cnt_next;

    logic [W_DIN-1:0]  slot_reg [NUM];
    logic [NUM-1:0]    slot_we;
    logic [CW-1:0]     wr_idx;
    logic [W_DOUT-1:0] buffer;

    logic              full;
    logic              last_beat;
    logic              din_fire;
    logic              dout_fire;

    // Port-side handshake: outputs are gated by rst so nothing is offered or
    // accepted while reset is asserted.
    always_comb begin
        full       = (state_reg == s_full) && !rst;
        dout_valid = full;
        dout_data  = full ? buffer : '0;
`ifdef DTI_DESER_PIPE_EN
        din_ready  = !rst && ((state_reg == s_fill) || dout_ready);
`else
        din_ready  = !rst && (state_reg == s_fill);
`endif
        din_fire   = din_valid && din_ready;
        dout_fire  = dout_valid && dout_ready;
        last_beat  = (cnt_reg == CW'(NUM - 1));
        // A beat accepted while a word is leaving always starts a new word.
        wr_idx     = (state_reg == s_fill) ? cnt_reg : '0;
    end

    // Next-state and beat-count logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            s_fill: begin
                if (din_fire) begin
                    if (last_beat) begin
                        cnt_next   = '0;
                        state_next = s_full;
                    end else begin
                        cnt_next   = cnt_reg + 1'b1;
                    end
                end
            end
            s_full: begin
                if (dout_fire) begin
                    state_next = s_fill;
                    cnt_next   = '0;
`ifdef DTI_DESER_PIPE_EN
                    if (din_fire) begin
                        if (NUM == 1) begin
                            // the incoming beat is already a complete word
                            state_next = s_full;
                            cnt_next   = '0;
                        end else begin
                            state_next = s_fill;
                            cnt_next   = CW'(1);
                        end
                    end
`endif
                end
            end
            default: begin
                state_next = s_fill;
                cnt_next   = '0;
            end
        endcase
    end

    // State and counter registers; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= s_fill;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // One storage slot per beat position, written only when its index is
    // the current write position of an accepted beat.
    generate
        for (genvar gi = 0; gi < NUM; gi++) begin : g_slot
            assign slot_we[gi] = din_fire && (wr_idx == CW'(gi));

            // Beat slot register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_reg[gi] <= '0;
                end else if (slot_we[gi]) begin
                    slot_reg[gi] <= din_data;
                end
            end

            assign buffer[gi*W_DIN +: W_DIN] = slot_reg[gi];
        end
    endgenerate

endmodule
